// File: rtl/sample_sequencer_if.sv
// Pacing/sample inputs and strobe/state outputs of the sample sequencer.
interface sample_sequencer_if;
  logic       tick;
  logic       active;
  logic [1:0] log;
  logic       en_in;
  logic       en_out;
  logic [1:0] est;
  logic       busy;

  modport master (output tick, active, log, input en_in, en_out, est, busy);
  modport slave  (input tick, active, log, output en_in, en_out, est, busy);
endinterface

// File: rtl/sample_sequencer.sv
// Sense/decide/actuate sequencer: strobes the input register each sample period and the output
// register when a newly stable logic value appears. Optional macro: ALARM_FASTPATH_EN.
module sample_sequencer #(
  parameter int unsigned PERIOD_TICKS = 4,
  parameter int unsigned STABLE_N     = 3
) (
  input  logic               clk,
  input  logic               rst,
  sample_sequencer_if.slave  sq
);

  localparam int unsigned      CNT_W     = 4;
  localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(STABLE_N);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(PERIOD_TICKS - 1);

  // Encoding doubles as the display state code.
  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_SAMPLE = 2'b01,
    S_EVAL   = 2'b10,
    S_HOLD   = 2'b11
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [CNT_W-1:0] r_stab_cnt;
  logic [1:0]       r_cand;
  logic [1:0]       r_committed;
  logic             r_en_in;
  logic             r_en_out;
  logic             r_busy;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_hold_nxt;
  logic [CNT_W-1:0] w_stab_nxt;
  logic [1:0]       w_cand_nxt;
  logic [1:0]       w_comm_nxt;
  logic             w_commit;

  // Next-state, counter and filter update.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_stab_nxt  = r_stab_cnt;
    w_cand_nxt  = r_cand;
    w_comm_nxt  = r_committed;
    w_commit    = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (sq.tick && sq.active) w_state_nxt = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_state_nxt = S_EVAL;
      end
      S_EVAL: begin
        w_cand_nxt = sq.log;
        if (sq.log == r_cand) begin
          w_stab_nxt = (r_stab_cnt >= STAB_MAX) ? STAB_MAX : r_stab_cnt + CNT_W'(1);
        end else begin
          w_stab_nxt = CNT_W'(1);
        end
`ifdef ALARM_FASTPATH_EN
        // A new alarm value skips the debounce; its release does not.
        if (sq.log[1] && (sq.log != r_committed)) w_stab_nxt = STAB_MAX;
`endif
        w_commit = (w_stab_nxt == STAB_MAX) && (w_cand_nxt != r_committed);
        if (w_commit) w_comm_nxt = w_cand_nxt;
        w_hold_nxt  = '0;
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (!sq.active) begin
          w_state_nxt = S_IDLE;
          w_hold_nxt  = '0;
        end else if (sq.tick) begin
          if (r_hold_cnt >= HOLD_LAST) begin
            w_state_nxt = S_SAMPLE;
            w_hold_nxt  = '0;
          end else begin
            w_hold_nxt = r_hold_cnt + CNT_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and output strobes, registered so they line up with the state code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_hold_cnt  <= '0;
      r_stab_cnt  <= '0;
      r_cand      <= '0;
      r_committed <= '0;
      r_en_in     <= 1'b0;
      r_en_out    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hold_cnt  <= w_hold_nxt;
      r_stab_cnt  <= w_stab_nxt;
      r_cand      <= w_cand_nxt;
      r_committed <= w_comm_nxt;
      r_en_in     <= (w_state_nxt == S_SAMPLE);
      r_en_out    <= w_commit;
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  assign sq.en_in  = r_en_in;
  assign sq.en_out = r_en_out;
  assign sq.est    = r_state;
  assign sq.busy   = r_busy;

endmodule

// File: tb/tb_sample_sequencer.sv
// Directed scoreboard bench for sample_sequencer (default instance plus a PERIOD_TICKS=1 instance).
module tb_sample_sequencer;

  localparam int STAB_N = 3;
  localparam int PER    = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_sequencer_if sq0 ();
  sample_sequencer_if sq1 ();

  sample_sequencer u_dut (.clk(clk), .rst(rst), .sq(sq0.slave));
  sample_sequencer #(.PERIOD_TICKS(1), .STABLE_N(STAB_N)) u_dut_p1 (.clk(clk), .rst(rst), .sq(sq1.slave));

  int         checks = 0;
  int         fails  = 0;
  logic       exp_q[$];
  logic [1:0] hist[$];
  logic [1:0] committed_m = 2'b00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected commit: the last STAB_N samples all equal and differ from the committed value.
  function automatic logic model_commit(input logic [1:0] lv);
    logic stable, fast, c;
    hist.push_back(lv);
    if (hist.size() > STAB_N) void'(hist.pop_front());
    stable = (hist.size() == STAB_N);
    foreach (hist[i]) if (hist[i] !== lv) stable = 1'b0;
    fast = 1'b0;
`ifdef ALARM_FASTPATH_EN
    fast = lv[1];
`endif
    c = (stable || fast) && (lv !== committed_m);
    if (c) committed_m = lv;
    return c;
  endfunction

  function automatic void model_reset();
    hist.delete();
    exp_q.delete();
    committed_m = 2'b00;
  endfunction

  // Pulse spaced ticks until the DUT enters SAMPLE (bounded).
  task automatic to_sample(output int ticks, output logic ok);
    int n;
    n = 0;
    ticks = 0;
    while (sq0.en_in !== 1'b1 && n < 64) begin
      sq0.tick = (n % 2 == 0);
      if (n % 2 == 0) ticks++;
      @(negedge clk);
      n++;
    end
    sq0.tick = 1'b0;
    ok = (sq0.en_in === 1'b1);
  endtask

  task automatic tick_once();
    sq0.tick = 1'b1;
    @(negedge clk);
    sq0.tick = 1'b0;
    @(negedge clk);
  endtask

  // One full sample period: S, E, first HOLD (en_out checked against scoreboard), second HOLD.
  task automatic run_period(input logic [1:0] lv, input int exp_ticks, input string tag);
    int   ticks;
    logic ok;
    sq0.log = lv;
    exp_q.push_back(model_commit(lv));
    to_sample(ticks, ok);
    chk({tag, ":reach_sample"}, 32'(ok), 32'd1);
    if (!ok) begin
      void'(exp_q.pop_front());
      return;
    end
    chk({tag, ":est_s"}, 32'(sq0.est), 32'd1);
    chk({tag, ":busy_s"}, 32'(sq0.busy), 32'd1);
    if (exp_ticks > 0) chk({tag, ":ticks"}, 32'(ticks), 32'(exp_ticks));
    @(negedge clk);
    chk({tag, ":est_e"}, 32'(sq0.est), 32'd2);
    chk({tag, ":en_in_e"}, 32'(sq0.en_in), 32'd0);
    @(negedge clk);
    chk({tag, ":est_h"}, 32'(sq0.est), 32'd3);
    chk({tag, ":en_out"}, 32'(sq0.en_out), 32'(exp_q.pop_front()));
    @(negedge clk);
    chk({tag, ":en_out_once"}, 32'(sq0.en_out), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int   ticks;
    logic ok;
    rst = 1'b1;
    sq0.tick = 1'b0; sq0.active = 1'b0; sq0.log = 2'b00;
    sq1.tick = 1'b0; sq1.active = 1'b0; sq1.log = 2'b00;
    repeat (2) @(negedge clk);
    chk("rst:en_in", 32'(sq0.en_in), 32'd0);
    chk("rst:en_out", 32'(sq0.en_out), 32'd0);
    chk("rst:est", 32'(sq0.est), 32'd0);
    chk("rst:busy", 32'(sq0.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Filter with a constant value: one commit on the third sample.
    sq0.active = 1'b1;
    for (int i = 0; i < 5; i++) run_period(2'b01, (i == 0) ? 1 : PER, "t2");

    // Glitch restarts the filter.
    for (int i = 0; i < 3; i++) run_period(2'b00, PER, "t3pre");
    run_period(2'b01, PER, "t3a");
    run_period(2'b01, PER, "t3b");
    run_period(2'b10, PER, "t3glitch");
    for (int i = 0; i < 3; i++) run_period(2'b01, PER, "t3c");

    // Alarm onset: immediate with fastpath, third sample otherwise.
    for (int i = 0; i < 3; i++) run_period(2'b00, PER, "t5pre");
    for (int i = 0; i < 3; i++) run_period(2'b10, PER, "t5alarm");
    for (int i = 0; i < 3; i++) run_period(2'b00, PER, "t5release");

    // Deactivate mid-HOLD, ignored tick in IDLE, restart.
    tick_once();
    tick_once();
    sq0.active = 1'b0;
    @(negedge clk);
    chk("t4:est_idle", 32'(sq0.est), 32'd0);
    chk("t4:busy_idle", 32'(sq0.busy), 32'd0);
    tick_once();
    chk("t4:tick_ignored", 32'(sq0.est), 32'd0);
    chk("t4:no_en_in", 32'(sq0.en_in), 32'd0);
    sq0.active = 1'b1;
    run_period(2'b00, 1, "t4restart");
    run_period(2'b00, PER, "t4full");

    // Reset during EVAL drops the pending en_out pulse.
    run_period(2'b01, PER, "rp1");
    run_period(2'b01, PER, "rp2");
    sq0.log = 2'b01;
    to_sample(ticks, ok);
    chk("rp:reach_sample", 32'(ok), 32'd1);
    @(negedge clk);
    chk("rp:est_e", 32'(sq0.est), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("rp:en_out_dropped", 32'(sq0.en_out), 32'd0);
    chk("rp:est", 32'(sq0.est), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Reset for two cycles in HOLD with hold_cnt=2.
    run_period(2'b00, 1, "t1pre");
    tick_once();
    tick_once();
    rst = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("t1:en_in", 32'(sq0.en_in), 32'd0);
      chk("t1:en_out", 32'(sq0.en_out), 32'd0);
      chk("t1:est", 32'(sq0.est), 32'd0);
      chk("t1:busy", 32'(sq0.busy), 32'd0);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) run_period(2'b01, (i == 0) ? 1 : PER, "t1post");

    // PERIOD_TICKS=1 with a tick every clock: S,E,H repeating.
    sq0.active = 1'b0;
    sq1.active = 1'b1;
    sq1.tick   = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("t6:est", 32'(sq1.est), (i % 3 == 0) ? 32'd1 : ((i % 3 == 1) ? 32'd2 : 32'd3));
      chk("t6:en_in", 32'(sq1.en_in), (i % 3 == 0) ? 32'd1 : 32'd0);
    end
    sq1.tick   = 1'b0;
    sq1.active = 1'b0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
